// File: rtl/sram_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_pkg
//  Brief    : Shared types for the SRAM bank arbiter (power states, port index)
//  Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        RETENTION = 2'd1,
        WAKE      = 2'd2
    } pwr_state_e;

    localparam int c_max_ports = 4;

    typedef logic [1:0] port_idx_t;

endpackage
`default_nettype wire

// File: rtl/sram_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bank_arbiter_if
//  Brief    : Requester bundle plus downstream SRAM-side signals of the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
interface sram_bank_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 10
);
    logic [NUM_PORTS-1:0]            req_i;
    logic [NUM_PORTS-1:0]            we_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_PORTS*32-1:0]         wdata_i;
    logic [NUM_PORTS*4-1:0]          be_i;
    logic [NUM_PORTS-1:0]            gnt_o;
    logic [NUM_PORTS-1:0]            rvalid_o;
    logic [31:0]                     rdata_o;
    logic                            sram_req_o;
    logic                            sram_we_o;
    logic [ADDR_WIDTH-1:0]           sram_addr_o;
    logic [31:0]                     sram_wdata_o;
    logic [3:0]                      sram_be_o;
    logic [31:0]                     sram_rdata_i;
    logic                            sram_ret_no;
    logic [1:0]                      ret_state_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, sram_req_o, sram_we_o, sram_addr_o,
               sram_wdata_o, sram_be_o, sram_ret_no, ret_state_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
        output gnt_o, rvalid_o, rdata_o, sram_req_o, sram_we_o, sram_addr_o,
               sram_wdata_o, sram_be_o, sram_ret_no, ret_state_o
    );
endinterface
`default_nettype wire

// File: rtl/sram_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_rr
//  Brief    : Combinational rotating-priority picker starting at i_ptr
//  Revision : 1.0 - initial release
// ============================================================================
module sram_arb_rr
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  port_idx_t            i_ptr,
    output logic [NUM_PORTS-1:0] o_gnt,
    output port_idx_t            o_idx,
    output logic                 o_valid
);

    logic [c_max_ports-1:0] w_req_ext;
    port_idx_t              w_cand;

    always_comb begin
        w_req_ext                = '0;
        w_req_ext[NUM_PORTS-1:0] = i_req;
        w_cand                   = '0;
        o_idx                    = '0;
        o_valid                  = 1'b0;
        o_gnt                    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = port_idx_t'((int'(i_ptr) + i) % NUM_PORTS);
            if (!o_valid && w_req_ext[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            o_gnt[p] = o_valid && (port_idx_t'(p) == o_idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bank_arbiter
//  Brief    : Round-robin sharing of one SRAM bank with idle-driven retention
//  Revision : 1.0 - initial release
// ============================================================================
module sram_bank_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int NUM_WORDS   = 1024,
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    sram_bank_arbiter_if.slave bus
);

    localparam int c_addr_w = $clog2(NUM_WORDS);
    localparam int c_idle_w = $clog2(IDLE_CYCLES + 2);
    localparam int c_wake_w = $clog2(WAKE_CYCLES + 1);

    typedef logic [c_idle_w-1:0] idle_cnt_t;
    typedef logic [c_wake_w-1:0] wake_cnt_t;

    pwr_state_e           r_state, w_state_nxt;
    idle_cnt_t            r_idle_cnt, w_idle_nxt;
    wake_cnt_t            r_wake_cnt, w_wake_nxt;
    port_idx_t            r_rr_ptr;
    port_idx_t            w_win_idx;
    logic [NUM_PORTS-1:0] w_pick_gnt;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [NUM_PORTS-1:0] r_rvalid;
    logic                 w_pick_valid;
    logic                 w_grant;
    logic                 w_any_req;

    sram_arb_rr #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .i_req   (bus.req_i),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_win_idx),
        .o_valid (w_pick_valid)
    );

    // Grants are masked while reset is held so nothing reaches the bank.
    assign w_any_req = |bus.req_i;
    assign w_grant   = w_pick_valid && (r_state == ACTIVE) && !rst_i;
    assign w_gnt     = w_grant ? w_pick_gnt : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ACTIVE;
            r_idle_cnt <= '0;
            r_wake_cnt <= '0;
            r_rr_ptr   <= '0;
            r_rvalid   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_wake_cnt <= w_wake_nxt;
            r_rvalid   <= w_gnt;
            if (w_grant) begin
                r_rr_ptr <= port_idx_t'((int'(w_win_idx) + 1) % NUM_PORTS);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = '0;
        w_wake_nxt  = '0;
        case (r_state)
            ACTIVE: begin
                if (!w_any_req) begin
                    if (int'(r_idle_cnt) < IDLE_CYCLES) begin
                        w_idle_nxt = r_idle_cnt + idle_cnt_t'(1);
                    end else begin
                        w_idle_nxt = r_idle_cnt;
                    end
                    if ((IDLE_CYCLES != 0) && (int'(r_idle_cnt) >= IDLE_CYCLES - 1) &&
                        (r_rvalid == '0)) begin
                        w_state_nxt = RETENTION;
                    end
                end
            end
            RETENTION: begin
                if (w_any_req) begin
                    w_state_nxt = WAKE;
                end
            end
            WAKE: begin
                // The request cycle seen in retention counts toward the wake time.
                w_wake_nxt = r_wake_cnt + wake_cnt_t'(1);
                if (int'(r_wake_cnt) + 1 >= WAKE_CYCLES - 1) begin
                    w_state_nxt = ACTIVE;
                end
            end
            default: w_state_nxt = ACTIVE;
        endcase
    end

    always_comb begin
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        bus.sram_be_o    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) begin
                bus.sram_we_o    = bus.we_i[p];
                bus.sram_addr_o  = bus.addr_i[p*c_addr_w +: c_addr_w];
                bus.sram_wdata_o = bus.wdata_i[p*32 +: 32];
                bus.sram_be_o    = bus.be_i[p*4 +: 4];
            end
        end
    end

    assign bus.sram_req_o  = w_grant;
    assign bus.gnt_o       = w_gnt;
    assign bus.rvalid_o    = r_rvalid;
    assign bus.rdata_o     = bus.sram_rdata_i;
    assign bus.sram_ret_no = (r_state != RETENTION);
    assign bus.ret_state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sram_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_bank_arbiter
//  Brief    : Self-checking bench for sram_bank_arbiter with a behavioural model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bank_arbiter;

    localparam int NP   = 2;
    localparam int NW   = 1024;
    localparam int AW   = 10;
    localparam int IDLE = 8;
    localparam int WAKE = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_bank_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus8 ();
    sram_bank_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus0 ();

    sram_bank_arbiter #(.NUM_PORTS(NP), .NUM_WORDS(NW), .IDLE_CYCLES(IDLE),
                        .WAKE_CYCLES(WAKE)) u_dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8));
    sram_bank_arbiter #(.NUM_PORTS(NP), .NUM_WORDS(NW), .IDLE_CYCLES(0),
                        .WAKE_CYCLES(WAKE)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));

    // Behavioural bank: one-cycle read, byte-masked write
    logic [31:0] mem [NW];
    always @(posedge clk) begin
        if (bus8.sram_req_o) begin
            if (bus8.sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus8.sram_be_o[b])
                        mem[bus8.sram_addr_o][8*b +: 8] <= bus8.sram_wdata_o[8*b +: 8];
            end else begin
                bus8.sram_rdata_i <= mem[bus8.sram_addr_o];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Stimulus
    logic [NP-1:0] s_req, s_we;
    logic [AW-1:0] s_addr [NP];
    logic [31:0]   s_wdata [NP];
    logic [3:0]    s_be [NP];

    // Reference model
    int          m_state, m_idle, m_ptr, m_resp;
    bit          m_resp_rd;
    logic [31:0] m_resp_data;
    longint      m_cyc, m_grant_at;
    logic [31:0] gold [NW];
    logic [NP-1:0] obs_gnt;

    task automatic drive();
        bus8.req_i = s_req;
        bus8.we_i  = s_we;
        for (int p = 0; p < NP; p++) begin
            bus8.addr_i[p*AW +: AW] = s_addr[p];
            bus8.wdata_i[p*32 +: 32] = s_wdata[p];
            bus8.be_i[p*4 +: 4]      = s_be[p];
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_idle = 0; m_ptr = 0; m_resp = -1; m_resp_rd = 0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        s_req = '1;
        drive();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk);
            check_val("rst_gnt", 32'(bus8.gnt_o), 32'd0);
            check_val("rst_rvalid", 32'(bus8.rvalid_o), 32'd0);
            check_val("rst_ret_n", 32'(bus8.sram_ret_no), 32'd1);
            check_val("rst_state", 32'(bus8.ret_state_o), 32'd0);
        end
        rst   = 1'b0;
        s_req = '0;
        model_reset();
    endtask

    task automatic step(input bit auto_drop);
        int win;
        logic [NP-1:0] eg, erv;
        bit pend;
        drive();
        #1;
        win = -1;
        if (m_state == 0)
            for (int i = 0; i < NP; i++) begin
                int p;
                p = (m_ptr + i) % NP;
                if (win < 0 && s_req[p]) win = p;
            end
        eg = '0;
        if (win >= 0) eg[win] = 1'b1;
        erv = '0;
        if (m_resp >= 0) erv[m_resp] = 1'b1;
        obs_gnt = bus8.gnt_o;
        check_val("gnt", 32'(bus8.gnt_o), 32'(eg));
        check_val("sram_req", 32'(bus8.sram_req_o), (win >= 0) ? 32'd1 : 32'd0);
        check_val("ret_n", 32'(bus8.sram_ret_no), (m_state != 1) ? 32'd1 : 32'd0);
        check_val("state", 32'(bus8.ret_state_o), 32'(m_state));
        check_val("rvalid", 32'(bus8.rvalid_o), 32'(erv));
        if (m_resp >= 0 && m_resp_rd) check_val("rdata", bus8.rdata_o, m_resp_data);
        if (win >= 0) begin
            check_val("sram_addr", 32'(bus8.sram_addr_o), 32'(s_addr[win]));
            check_val("sram_we", 32'(bus8.sram_we_o), 32'(s_we[win]));
            if (s_we[win]) begin
                check_val("sram_wdata", bus8.sram_wdata_o, s_wdata[win]);
                check_val("sram_be", 32'(bus8.sram_be_o), 32'(s_be[win]));
            end
        end
        pend = (m_resp >= 0);
        if (win >= 0) begin
            if (s_we[win]) begin
                for (int b = 0; b < 4; b++)
                    if (s_be[win][b]) gold[s_addr[win]][8*b +: 8] = s_wdata[win][8*b +: 8];
                m_resp_rd = 0;
            end else begin
                m_resp_data = gold[s_addr[win]];
                m_resp_rd   = 1;
            end
            m_ptr = (win + 1) % NP;
            if (auto_drop) s_req[win] = 1'b0;
        end
        m_resp = win;
        case (m_state)
            0: if (|s_req || win >= 0) m_idle = 0;
               else begin
                   m_idle++;
                   if (m_idle >= IDLE && !pend) m_state = 1;
               end
            1: if (|bus8.req_i) begin m_state = 2; m_grant_at = m_cyc + WAKE; end
            default: if (m_cyc + 1 == m_grant_at) begin m_state = 0; m_idle = 0; end
        endcase
        m_cyc++;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic set_port(input int p, input bit we, input int addr,
                            input logic [31:0] d, input logic [3:0] be);
        s_req[p] = 1'b1; s_we[p] = we; s_addr[p] = AW'(addr); s_wdata[p] = d; s_be[p] = be;
    endtask

    initial begin
        int gap, lat;
        for (int i = 0; i < NW; i++) begin mem[i] = '0; gold[i] = '0; end
        s_req = '0; s_we = '0; m_cyc = 0; m_grant_at = 0;
        for (int p = 0; p < NP; p++) begin s_addr[p] = '0; s_wdata[p] = '0; s_be[p] = '0; end
        bus0.req_i = '0; bus0.we_i = '0; bus0.addr_i = '0; bus0.wdata_i = '0;
        bus0.be_i = '0; bus0.sram_rdata_i = '0;

        do_reset();

        // Both ports contend: strict alternation starting at port 0
        set_port(0, 0, 3, 0, 4'hF);
        set_port(1, 0, 5, 0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            step(0);
            check_val("t2_gnt", 32'(obs_gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        s_req = '0;
        step(1);

        // Write then read back through port 1
        set_port(1, 1, 'h10, 32'hDEADBEEF, 4'hF);
        step(1);
        set_port(1, 0, 'h10, 0, 4'hF);
        step(1);
        check_val("t3_rvalid", 32'(bus8.rvalid_o), 32'd2);
        check_val("t3_rdata", bus8.rdata_o, 32'hDEADBEEF);
        step(1);

        // Partial byte-enable merge
        set_port(0, 1, 'h20, 32'h11223344, 4'hF);
        step(1);
        set_port(0, 1, 'h20, 32'hAABBCCDD, 4'b0101);
        step(1);
        set_port(0, 0, 'h20, 0, 4'hF);
        step(1);
        check_val("t5_rdata", bus8.rdata_o, 32'h11BB33DD);
        step(1);

        // Idle into retention, then wake on demand
        do_reset();
        for (int k = 0; k < IDLE; k++) step(1);
        check_val("t4_ret_n", 32'(bus8.sram_ret_no), 32'd0);
        set_port(0, 0, 'h10, 0, 4'hF);
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            step(1);
            if (obs_gnt[0]) lat = k;
        end
        check_val("t4_wake_lat", 32'(lat), 32'd4);
        check_val("t4_rdata", bus8.rdata_o, 32'hDEADBEEF);
        step(1);

        // Randomised traffic with idle gaps and a mid-run reset
        gap = 0;
        for (int c = 0; c < 800; c++) begin
            if (c == 400) do_reset();
            if (gap > 0) gap--;
            else if ($urandom_range(0, 59) == 0) gap = $urandom_range(6, 20);
            for (int p = 0; p < NP; p++) begin
                if (!s_req[p]) begin
                    if (gap == 0 && $urandom_range(0, 99) < 35)
                        set_port(p, 1'($urandom_range(0, 1)), $urandom_range(0, 31),
                                 $urandom, 4'($urandom_range(1, 15)));
                end else if ($urandom_range(0, 99) < 3) begin
                    s_req[p] = 1'b0;
                end
            end
            step(1);
        end

        // Retention disabled: must never leave ACTIVE
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            check_val("t6_ret_n", 32'(bus0.sram_ret_no), 32'd1);
            check_val("t6_state", 32'(bus0.ret_state_o), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
